instr_fetch_unit: RTL

//  Front end of the 8-bit processor: holds the program in an internal instruction store,

---
 rtl/instr_fetch_unit_pkg.sv | 27 ++
 rtl/instr_store.sv | 18 +
 rtl/instr_fetch_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: ISA opcodes, instruction layout and fetch FSM states
package instr_fetch_unit_pkg;
  localparam int INSTR_W = 18;
  localparam logic [3:0] OP_ROT  = 4'b0000;
  localparam logic [3:0] OP_MOVA = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_INR  = 4'b0101;
  localparam logic [3:0] OP_DCR  = 4'b0110;
  localparam logic [3:0] OP_ADI  = 4'b0111;
  localparam logic [3:0] OP_HLT  = 4'b1000;
  localparam logic [3:0] OP_SBI  = 4'b1001;
  localparam logic [3:0] OP_REG  = 4'b1010;
  localparam logic [3:0] OP_MOV  = 4'b1011;
  localparam logic [3:0] OP_MVI  = 4'b1100;
  localparam logic [3:0] OP_ORI  = 4'b1101;
  localparam logic [3:0] OP_ANI  = 4'b1110;
  localparam logic [3:0] OP_XRI  = 4'b1111;
  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm;
  } instr_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_HOLD, S_HALT} state_t;
endpackage

// File: rtl/instr_store.sv
// instr_store: program memory with one synchronous write port and one synchronous read port
module instr_store import instr_fetch_unit_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);
  logic [INSTR_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches from the program store and holds each instruction's fields
// stable for the handshake-free decoder (longer for MUL), with stall and halt/resume.
module instr_fetch_unit import instr_fetch_unit_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int HOLD_CYCLES = 2,
  parameter int MUL_HOLD = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [3:0]         bit1,
  output logic [2:0]         bit2,
  output logic [2:0]         bit3,
  output logic [7:0]         bit4,
  output logic               issue,
  output logic [AW-1:0]      pc,
  output logic               halted
);
  state_t state_q, state_d;
  instr_t f_q, f_d, rd;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0] cnt_q, cnt_d;
  logic issue_q, issue_d;
  logic idle_or_halt;
  assign idle_or_halt = (state_q == S_IDLE) || (state_q == S_HALT);
  instr_store #(.DEPTH(DEPTH)) u_store (
    .clk     (clk),
    .we_i    (prog_we && idle_or_halt),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q),
    .rdata_o (rd)
  );
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    issue_d = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: state_d = start ? S_FETCH : state_q;
      S_FETCH: state_d = stall ? S_FETCH : S_ISSUE;
      S_ISSUE: begin
        f_d     = rd;
        issue_d = 1'b1;
        pc_d    = pc_q + AW'(1);
        cnt_d   = (rd.op == OP_MUL) ? 8'(MUL_HOLD) : 8'(HOLD_CYCLES);
        state_d = (rd.op == OP_HLT) ? S_HALT : S_HOLD;
      end
      S_HOLD: begin
        cnt_d   = stall ? cnt_q : cnt_q - 8'd1;
        state_d = (!stall && cnt_q <= 8'd1) ? S_FETCH : S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      f_q     <= '{op: OP_REG, rd: 3'd0, rs: 3'd0, imm: 8'd0};
      cnt_q   <= '0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      issue_q <= issue_d;
    end
  end
  // The HLT issue cycle already sits in HALT; halted rises one cycle later.
  assign halted = (state_q == S_HALT) && !issue_q;
  assign issue  = issue_q;
  assign pc     = pc_q;
  assign bit1   = f_q.op;
  assign bit2   = f_q.rd;
  assign bit3   = f_q.rs;
  assign bit4   = f_q.imm;
endmodule
